// File: rtl/seg7_scan_driver.sv
// Two-digit common-anode 7-segment scanner: captures BCD_ten/BCD_one on Load, then alternates digits with blanking gaps.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks the tens digit when it holds 0.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] BCD_ten,
  input  logic [3:0] BCD_one,
  input  logic       Load,
  output logic [6:0] Seg,
  output logic [1:0] DigitEn
);

  localparam int SPAN_RB  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_SPAN = (SPAN_RB > 2) ? SPAN_RB : 2;
  localparam int CW       = $clog2(CNT_SPAN);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    SHOW_ONE,
    BLANK_TO_TEN,
    SHOW_TEN,
    BLANK_TO_ONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [3:0]    ten_q;
  logic [3:0]    one_q;
  logic [6:0]    seg_d;
  logic [1:0]    digit_d;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Load is a plain strobe with no handshake: every rising edge that sees Load=1
  // overwrites both latches; nothing is ever back-pressured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ten_q <= 4'h0;
      one_q <= 4'h0;
    end else if (Load) begin
      ten_q <= BCD_ten;
      one_q <= BCD_one;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SHOW_ONE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? '0 : cnt + CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    seg_d      = 7'h7F;
    digit_d    = 2'b11;
    case (state)
      SHOW_ONE: begin
        digit_d = 2'b10;
        seg_d   = dec(one_q);
        if (cnt == SHOW_LAST) begin
          if (BLANK_CYCLES == 0) state_next = SHOW_TEN;
          else                   state_next = BLANK_TO_TEN;
        end
      end
      BLANK_TO_TEN: begin
        if (cnt == BLANK_LAST) state_next = SHOW_TEN;
      end
      SHOW_TEN: begin
        digit_d = 2'b01;
        seg_d   = dec(ten_q);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (ten_q == 4'h0) seg_d = 7'h7F;
`endif
        if (cnt == SHOW_LAST) begin
          if (BLANK_CYCLES == 0) state_next = SHOW_ONE;
          else                   state_next = BLANK_TO_ONE;
        end
      end
      default: begin
        if (cnt == BLANK_LAST) state_next = SHOW_ONE;
      end
    endcase
  end

  // Outputs lag state and latches by one cycle so the pads see glitch-free flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Seg     <= 7'h7F;
      DigitEn <= 2'b11;
    end else begin
      Seg     <= seg_d;
      DigitEn <= digit_d;
    end
  end

endmodule
